// File: rtl/seq_match_ctrl_if.sv
// Word-level handshake bundle for seq_match_ctrl: input word channel and
// match-count result channel, each with valid/ready.
interface seq_match_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] match_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, match_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, match_count
  );
endinterface

// File: rtl/seq_match_ctrl.sv
// Serialises an accepted word LSB-first into a one-hot "last two inputs equal"
// detector (A..E, z = C|E) and returns the number of z assertions.
module seq_match_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_match_ctrl_if.slave      bus,
  output logic                 busy,
  output logic                 z_mon,
  output logic [4:0]           det_state
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [4:0] DET_A = 5'b00001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ctrl_state_t;

  ctrl_state_t      state_r,     state_nxt_s;
  logic [WIDTH-1:0] shreg_r,     shreg_nxt_s;
  logic [IDX_W-1:0] bidx_r,      bidx_nxt_s;
  logic [4:0]       det_r,       det_nxt_s;
  logic [CNT_W-1:0] cnt_r,       cnt_nxt_s;
  logic             z_r,         z_nxt_s;
  logic             in_ready_r,  in_ready_nxt_s;
  logic             out_valid_r, out_valid_nxt_s;
  logic             busy_r,      busy_nxt_s;
  logic [4:0]       step_s;

  // One detector step; state vector is {E,D,C,B,A}, A is never re-entered.
  function automatic logic [4:0] det_step(input logic [4:0] s, input logic w);
    logic [4:0] n;
    n[0] = 1'b0;
    n[1] = ~w & (s[0] | s[3] | s[4]);
    n[2] = ~w & (s[1] | s[2]);
    n[3] =  w & (s[0] | s[1] | s[2]);
    n[4] =  w & (s[3] | s[4]);
    return n;
  endfunction

  // Next-state and next-output logic for controller, detector and counter.
  always_comb begin
    state_nxt_s     = state_r;
    shreg_nxt_s     = shreg_r;
    bidx_nxt_s      = bidx_r;
    det_nxt_s       = det_r;
    cnt_nxt_s       = cnt_r;
    z_nxt_s         = z_r;
    in_ready_nxt_s  = in_ready_r;
    out_valid_nxt_s = out_valid_r;
    busy_nxt_s      = busy_r;
    step_s          = det_step(det_r, shreg_r[0]);

    case (state_r)
      IDLE: begin
        if (bus.in_valid && in_ready_r) begin
          shreg_nxt_s    = bus.in_data;
          bidx_nxt_s     = {IDX_W{1'b0}};
          det_nxt_s      = DET_A;
          cnt_nxt_s      = {CNT_W{1'b0}};
          z_nxt_s        = 1'b0;
          in_ready_nxt_s = 1'b0;
          busy_nxt_s     = 1'b1;
          state_nxt_s    = SHIFT;
        end else begin
          in_ready_nxt_s = 1'b1;
          busy_nxt_s     = 1'b0;
        end
      end

      SHIFT: begin
        shreg_nxt_s = shreg_r >> 1;
        bidx_nxt_s  = bidx_r + IDX_W'(1);
        det_nxt_s   = step_s;
        z_nxt_s     = step_s[2] | step_s[4];
        // Count saturates rather than wrapping if CNT_W is undersized.
        if ((step_s[2] | step_s[4]) && (cnt_r != {CNT_W{1'b1}})) begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
        if (bidx_r == LAST_IDX) begin
          busy_nxt_s      = 1'b0;
          out_valid_nxt_s = 1'b1;
          state_nxt_s     = DONE;
        end else begin
          busy_nxt_s      = 1'b1;
        end
      end

      DONE: begin
        if (out_valid_r && bus.out_ready) begin
          out_valid_nxt_s = 1'b0;
          in_ready_nxt_s  = 1'b1;
          state_nxt_s     = IDLE;
        end else begin
          out_valid_nxt_s = 1'b1;
        end
      end

      default: begin
        state_nxt_s     = IDLE;
        shreg_nxt_s     = {WIDTH{1'b0}};
        bidx_nxt_s      = {IDX_W{1'b0}};
        det_nxt_s       = DET_A;
        cnt_nxt_s       = {CNT_W{1'b0}};
        z_nxt_s         = 1'b0;
        in_ready_nxt_s  = 1'b1;
        out_valid_nxt_s = 1'b0;
        busy_nxt_s      = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any word in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      shreg_r     <= {WIDTH{1'b0}};
      bidx_r      <= {IDX_W{1'b0}};
      det_r       <= DET_A;
      cnt_r       <= {CNT_W{1'b0}};
      z_r         <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      shreg_r     <= shreg_nxt_s;
      bidx_r      <= bidx_nxt_s;
      det_r       <= det_nxt_s;
      cnt_r       <= cnt_nxt_s;
      z_r         <= z_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.match_count = cnt_r;
  assign busy            = busy_r;
  assign z_mon           = z_r;
  assign det_state       = det_r;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Scoreboard bench for seq_match_ctrl: expectations queued at accept,
// compared when the result handshake completes.
module tb_seq_match_ctrl;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [4:0]       det;
    logic             z;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       busy, z_mon;
  logic [4:0] det_state;

  seq_match_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  seq_match_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .busy(busy), .z_mon(z_mon), .det_state(det_state)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  bit   watch_onehot = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int cnt, input logic [4:0] det, input logic z);
    exp_t e;
    e.cnt = CNT_W'(cnt);
    e.det = det;
    e.z   = z;
    return e;
  endfunction

  // Reference: a match is any bit equal to its predecessor; final state
  // follows from the last bit and whether it repeated.
  function automatic exp_t model(input logic [WIDTH-1:0] d);
    int   n = 0;
    logic eq;
    for (int i = 1; i < WIDTH; i++) if (d[i] == d[i-1]) n++;
    eq = (d[WIDTH-1] == d[WIDTH-2]);
    if (d[WIDTH-1]) return mk(n, eq ? 5'b10000 : 5'b01000, eq);
    else            return mk(n, eq ? 5'b00100 : 5'b00010, eq);
  endfunction

  always @(negedge clk) begin
    if (watch_onehot && reset) check_val("onehot", 32'($countones(det_state)), 32'd1);
  end

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_in_ready"},  32'(bus.in_ready),    32'd1);
    check_val({tag, "_out_valid"}, 32'(bus.out_valid),   32'd0);
    check_val({tag, "_busy"},      32'(busy),            32'd0);
    check_val({tag, "_count"},     32'(bus.match_count), 32'd0);
    check_val({tag, "_det"},       32'(det_state),       32'h01);
    check_val({tag, "_z"},         32'(z_mon),           32'd0);
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check_val({tag, "_count"}, 32'(bus.match_count), 32'(e.cnt));
    check_val({tag, "_det"},   32'(det_state),       32'(e.det));
    check_val({tag, "_z"},     32'(z_mon),           32'(e.z));
  endtask

  // Entered and left at posedge+1.
  task automatic send_word(input logic [WIDTH-1:0] d, input exp_t e);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int n = 0; n < 40; n++) begin
      if (bus.in_ready) begin
        sb.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check_val("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  // Entered one step after the accepting edge; checks latency and result.
  task automatic get_result(input string tag);
    int n;
    bus.out_ready = 1'b1;
    for (n = 0; n < 40 && !bus.out_valid; n++) begin
      @(posedge clk); #1;
      if (n == 0) check_val({tag, "_busy"}, 32'(busy), 32'd1);
    end
    check_val({tag, "_latency"}, 32'(n), 32'(WIDTH));
    if (!bus.out_valid) begin
      bus.out_ready = 1'b0;
      return;
    end
    compare_pop(tag);
    @(posedge clk); #1;
    check_val({tag, "_ov_clr"}, 32'(bus.out_valid), 32'd0);
    check_val({tag, "_rdy_set"}, 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    bit saw_ov;
    int n;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    reset         = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1 check_reset_vals("rst");
    @(posedge clk); #1;
    watch_onehot = 1'b1;

    send_word(8'h00, mk(7, 5'b00100, 1'b1)); get_result("w00");
    send_word(8'hFF, mk(7, 5'b10000, 1'b1)); get_result("wff");
    send_word(8'h55, mk(0, 5'b00010, 1'b0)); get_result("w55");
    send_word(8'h33, mk(4, 5'b00100, 1'b1)); get_result("w33");
    repeat (6) begin
      d = WIDTH'($urandom);
      send_word(d, model(d));
      get_result("rnd");
    end

    // Back-pressure in DONE with a pending word.
    send_word(8'hFF, mk(7, 5'b10000, 1'b1));
    for (n = 0; n < 40 && !bus.out_valid; n++) begin
      @(posedge clk); #1;
    end
    check_val("bp_reach_done", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_val("bp_ov_hold",  32'(bus.out_valid),   32'd1);
      check_val("bp_cnt_hold", 32'(bus.match_count), 32'd7);
      check_val("bp_rdy_low",  32'(bus.in_ready),    32'd0);
    end
    bus.out_ready = 1'b1;
    compare_pop("bp");
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_val("bp_rdy_next", 32'(bus.in_ready),  32'd1);
    check_val("bp_ov_next",  32'(bus.out_valid), 32'd0);
    check_val("bp_not_busy", 32'(busy),          32'd0);
    sb.push_back(mk(7, 5'b00100, 1'b1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_val("bp_accepted", 32'(bus.in_ready), 32'd0);
    get_result("bp_next");

    // Abort at bit index 3.
    send_word(8'hFF, mk(7, 5'b10000, 1'b1));
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1 check_reset_vals("abort");
    sb.delete();
    #4 reset = 1'b1;
    @(posedge clk); #1;
    saw_ov = 1'b0;
    for (int i = 0; i < 15; i++) begin
      saw_ov |= bus.out_valid;
      @(posedge clk); #1;
    end
    check_val("abort_no_ov", 32'(saw_ov), 32'd0);
    check_val("abort_idle_rdy", 32'(bus.in_ready), 32'd1);

    send_word(8'h33, mk(4, 5'b00100, 1'b1)); get_result("post_abort");

    watch_onehot = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/seq_match_ctrl.md
Name: seq_match_ctrl

Overview:
- Sequencing controller for the team's one-hot "last two inputs equal" detector (states A–E, z = C|E).
- Accepts a parallel word over a valid/ready handshake and serialises it LSB-first into an embedded one-hot detector, one bit per clock.
- Counts detector matches (z assertions) and returns the count over a second valid/ready handshake.
- Sits between a word-oriented producer/consumer and the bit-serial detector datapath.

Parameters:
- WIDTH, 8: bits per input word, at least 1.
- CNT_W, 4: width of match_count; must hold WIDTH-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low (0 = reset).
- in_valid  in  1  producer has a word on in_data.
- in_ready  out  1  controller can accept a word.
- in_data  in  WIDTH  word to scan; bit 0 is applied first.
- out_valid  out  1  match_count is valid.
- out_ready  in  1  consumer accepts the result.
- match_count  out  CNT_W  number of z assertions during the word.
- busy  out  1  high in SHIFT.
- z_mon  out  1  detector z, equal to C|E of the current detector state.
- det_state  out  5  detector state as {E,D,C,B,A}, one-hot.

Behaviour:
- Reset (asynchronous, while reset==0):
  - Controller goes to IDLE; detector goes to A, so det_state=5'b00001.
  - in_ready=1, out_valid=0, busy=0, match_count=0, z_mon=0, shift register=0, bit index=0.
- Controller FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid&in_ready: load in_data into the shift register, force the detector to A, clear match_count and the bit index, then go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1.
  - Each edge applies w=shreg[0], shifts the register right, and increments the bit index.
  - Detector next state:
    - A'=0
    - B'=~w&(A|D|E)
    - C'=~w&(B|C)
    - D'=w&(A|B|C)
    - E'=w&(D|E)
  - If the next state is C or E, match_count increments on the same edge, saturating at all-ones.
  - The edge that applies bit WIDTH-1 moves the controller to DONE.
- Latency: the accept handshake is edge 0; shifts occur on edges 1..WIDTH; out_valid=1 after edge WIDTH.
- DONE:
  - out_valid=1 (registered); match_count, det_state and z_mon hold.
  - On an edge with out_valid&out_ready: go to IDLE, out_valid=0 and in_ready=1 in the next cycle. There is no same-cycle bypass to a new word.
- Detector state persists through DONE and IDLE; it is re-initialised to A only on accept.
- Boundary conditions:
  - The first bit from A can never match, so the maximum count is WIDTH-1.
  - WIDTH=1 always yields 0.
  - in_valid while in_ready=0 is ignored; the producer holds in_data until the handshake.
  - out_ready while out_valid=0 has no effect.
  - Reset asserted in SHIFT or DONE aborts immediately: the word is discarded, no out_valid is produced, and the bench sees the reset values above.
  - det_state must be one-hot at all times outside reset; all-zero or multi-hot is a bug.

Test Plan:
- Assert reset low mid-cycle, then release -> outputs read immediately: in_ready=1, out_valid=0, match_count=0, det_state=5'b00001, z_mon=0.
- in_data=8'h00 (WIDTH=8) -> out_valid 8 edges after accept; match_count=7, det_state=5'b00100, z_mon=1.
- in_data=8'hFF -> match_count=7, det_state=5'b10000, z_mon=1.
- in_data=8'h55 (LSB-first 1,0,1,0,...) -> path A,D,B,D,...,B; match_count=0, det_state=5'b00010, z_mon=0.
- in_data=8'h33 (LSB-first 1,1,0,0,1,1,0,0) -> path A,D,E,B,C,D,E,B,C; match_count=4, det_state=5'b00100.
- Back-pressure and abort:
  - Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with 8'h00 -> out_valid and match_count stay stable, and in_ready=0.
  - Then raise out_ready -> in_ready=1 next cycle, and the pending word is accepted one edge later.
  - Separately, assert reset at bit index 3 -> state aborts to the reset values and no out_valid is produced.
